// File: rtl/sram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_if
//   Bundles the three buses around the SRAM port arbiter: the IF-stage fetch
//   port, the MEM-stage data port, and the single-port SRAM port.
//
//   Parameters
//     ADDR_W  address width of both CPU ports and the SRAM
//     DATA_W  data width; byte-enable width is DATA_W/8
//
//   Modports
//     slave   arbiter view: receives fetch/data requests and SRAM read data,
//             drives handshakes, read data and the SRAM command
//     master  environment view (CPU pipeline + SRAM): the mirror image
// -----------------------------------------------------------------------------
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    // Fetch port
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // Data port
    logic              data_req;
    logic [BE_W-1:0]   data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // SRAM port
    logic              sram_en;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wen, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wen, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one synchronous single-port SRAM between the IF-stage fetch port
//   and the MEM-stage data port. At most one request is granted per cycle
//   (combinational addr_ok); the response (data_ok) follows exactly one cycle
//   later, so a new grant can overlap the previous response (1 op/cycle).
//   Data requests win, except that after STARVE_MAX consecutive data grants
//   with a fetch waiting, the fetch is granted.
//
//   Parameters
//     ADDR_W      address width
//     DATA_W      data width (byte enables = DATA_W/8)
//     STARVE_MAX  data grants tolerated while a fetch waits (>= 1)
//     CNT_W       performance counter width (only with ARB_PERF_EN)
//
//   Ports
//     clk     rising-edge clock
//     reset   synchronous active-high reset
//     cancel  pipeline flush: blocks grants and drops the response due now
//     bus     sram_port_arbiter_if.slave (fetch, data and SRAM buses)
//     perf_inst_grants / perf_data_grants / perf_conflicts
//             wrapping event counters, present only with ARB_PERF_EN
//
//   Build option
//     `define ARB_PERF_EN  adds the CNT_W parameter and the perf_* outputs
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
`ifdef ARB_PERF_EN
    ,
    parameter int unsigned CNT_W      = 32
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cancel,
    sram_port_arbiter_if.slave     bus
`ifdef ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]       perf_inst_grants,
    output logic [CNT_W-1:0]       perf_data_grants,
    output logic [CNT_W-1:0]       perf_conflicts
`endif
);
    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned STREAK_W = $clog2(STARVE_MAX + 1);

    // Who owns the response returning from the SRAM this cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DATA
    } owner_t;

    owner_t              owner_q, owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic                gnt_inst;
    logic                gnt_data;
    logic                starved;

    logic                sram_en_d;
    logic [BE_W-1:0]     sram_wen_d;
    logic [ADDR_W-1:0]   sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_d;

    assign starved = (streak_q == STREAK_W'(STARVE_MAX));

    // -------------------------------------------------------------------------
    // Grant selection, response ownership and starvation streak
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        owner_d  = OWN_NONE;
        streak_d = streak_q;

        if (!reset && !cancel) begin
            if (bus.inst_req && (!bus.data_req || starved)) begin
                gnt_inst = 1'b1;
            end else if (bus.data_req) begin
                gnt_data = 1'b1;
            end
        end

        if (gnt_inst) begin
            owner_d = OWN_INST;
        end else if (gnt_data) begin
            owner_d = OWN_DATA;
        end

        // The streak only measures an uninterrupted wait of a live fetch;
        // a flush or reset also ends that wait.
        if (reset || cancel || !bus.inst_req || gnt_inst) begin
            streak_d = '0;
        end else if (gnt_data && !starved) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= OWN_NONE;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    // -------------------------------------------------------------------------
    // SRAM command: driven from the granted port, idle (all zero) otherwise
    // -------------------------------------------------------------------------
    always_comb begin
        sram_en_d    = 1'b0;
        sram_wen_d   = '0;
        sram_addr_d  = '0;
        sram_wdata_d = '0;

        if (gnt_inst) begin
            sram_en_d   = 1'b1;
            sram_addr_d = bus.inst_addr;
        end else if (gnt_data) begin
            sram_en_d    = 1'b1;
            sram_wen_d   = bus.data_wen;
            sram_addr_d  = bus.data_addr;
            sram_wdata_d = bus.data_wdata;
        end
    end

    assign bus.sram_en    = sram_en_d;
    assign bus.sram_wen   = sram_wen_d;
    assign bus.sram_addr  = sram_addr_d;
    assign bus.sram_wdata = sram_wdata_d;

    // -------------------------------------------------------------------------
    // Handshakes. Responses are masked combinationally by reset and cancel so
    // an in-flight response is dropped in the very cycle it would appear.
    // -------------------------------------------------------------------------
    assign bus.inst_addr_ok = gnt_inst;
    assign bus.data_addr_ok = gnt_data;
    assign bus.inst_data_ok = (owner_q == OWN_INST) && !cancel && !reset;
    assign bus.data_data_ok = (owner_q == OWN_DATA) && !cancel && !reset;

    // Read data is a straight pass-through; only data_ok qualifies it.
    assign bus.inst_rdata = bus.sram_rdata;
    assign bus.data_rdata = bus.sram_rdata;

`ifdef ARB_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^CNT_W)
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] perf_inst_q, perf_inst_d;
    logic [CNT_W-1:0] perf_data_q, perf_data_d;
    logic [CNT_W-1:0] perf_conf_q, perf_conf_d;

    always_comb begin
        perf_inst_d = perf_inst_q + CNT_W'(gnt_inst);
        perf_data_d = perf_data_q + CNT_W'(gnt_data);
        perf_conf_d = perf_conf_q + CNT_W'(bus.inst_req && bus.data_req && !cancel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_inst_q <= '0;
            perf_data_q <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_inst_q <= perf_inst_d;
            perf_data_q <= perf_data_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_inst_grants = perf_inst_q;
    assign perf_data_grants = perf_data_q;
    assign perf_conflicts   = perf_conf_q;
`endif

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
    a_one_grant: assert property (@(posedge clk) disable iff (reset)
        !(bus.inst_addr_ok && bus.data_addr_ok));

    a_streak_bound: assert property (@(posedge clk) disable iff (reset)
        streak_q <= STREAK_W'(STARVE_MAX));

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cancel = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_EN
    logic [31:0] p_i, p_d, p_c;
`endif

    sram_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(SM)
`ifdef ARB_PERF_EN
        ,
        .CNT_W(32)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .cancel(cancel),
        .bus(bus)
`ifdef ARB_PERF_EN
        ,
        .perf_inst_grants(p_i),
        .perf_data_grants(p_d),
        .perf_conflicts(p_c)
`endif
    );

    // ---------------- SRAM behavioural model (1-cycle read latency) ----------
    function automatic logic [31:0] init_word(input int i);
        return {16'hC0DE, 8'(i), 8'(~i)};
    endfunction

    logic [31:0] mem [256];
    logic [31:0] rdata_q;
    assign bus.sram_rdata = rdata_q;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (bus.sram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.sram_wen[b]) mem[bus.sram_addr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            rdata_q <= mem[bus.sram_addr[9:2]];
        end
    end

    // ---------------- Scoreboard and reference state -------------------------
    typedef struct {
        int          due;
        bit          wr;
        logic [31:0] data;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    logic [31:0] ref_mem [256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starve = 0;
    int n_i = 0, n_d = 0, n_c = 0;

    logic        inst_pend = 1'b0, data_pend = 1'b0;
    logic [31:0] ia = '0, da = '0, dwd = '0;
    logic [3:0]  dwe = '0;
    logic        rst_v = 1'b1, can_v = 1'b0;
    logic        last_gi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return {22'b0, w, 2'b00};
    endfunction

    // One clock cycle: apply requests, predict the grant from the arbitration
    // rules, compare, and queue the response due next cycle.
    task automatic step();
        bit ei, ed;
        @(posedge clk);
        #1;
        cyc++;
        reset          = rst_v;
        cancel         = can_v;
        bus.inst_req   = inst_pend;
        bus.inst_addr  = ia;
        bus.data_req   = data_pend;
        bus.data_addr  = da;
        bus.data_wen   = dwe;
        bus.data_wdata = dwd;
        if (rst_v || can_v) begin
            if (iq.size() > 0 && iq[$].due == cyc) void'(iq.pop_back());
            if (dq.size() > 0 && dq[$].due == cyc) void'(dq.pop_back());
        end
        #1;
        ei = 1'b0;
        ed = 1'b0;
        if (!rst_v && !can_v) begin
            if (inst_pend && (!data_pend || starve >= SM)) ei = 1'b1;
            else if (data_pend) ed = 1'b1;
        end
        check("inst_addr_ok", 32'(bus.inst_addr_ok), 32'(ei));
        check("data_addr_ok", 32'(bus.data_addr_ok), 32'(ed));
        check("sram_en", 32'(bus.sram_en), 32'(ei | ed));
        if (ei) begin
            check("sram_addr_inst", bus.sram_addr, ia);
            check("sram_wen_inst", 32'(bus.sram_wen), 32'h0);
            iq.push_back('{due: cyc + 1, wr: 1'b0, data: ref_mem[ia[9:2]]});
        end else if (ed) begin
            check("sram_addr_data", bus.sram_addr, da);
            check("sram_wen_data", 32'(bus.sram_wen), 32'(dwe));
            if (dwe != 4'h0) check("sram_wdata", bus.sram_wdata, dwd);
            dq.push_back('{due: cyc + 1, wr: (dwe != 4'h0), data: ref_mem[da[9:2]]});
            for (int b = 0; b < 4; b++)
                if (dwe[b]) ref_mem[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
        end else begin
            check("sram_wen_idle", 32'(bus.sram_wen), 32'h0);
        end
        last_gi = bus.inst_addr_ok;

        if (rst_v || can_v || !inst_pend || ei) starve = 0;
        else if (ed && starve < SM) starve++;

        if (rst_v) begin
            n_i = 0; n_d = 0; n_c = 0;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        end else begin
            n_i += int'(ei);
            n_d += int'(ed);
            if (!can_v && inst_pend && data_pend) n_c++;
        end
        if (ei) inst_pend = 1'b0;
        if (ed) data_pend = 1'b0;
    endtask

    // ---------------- Response monitor ----------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.inst_data_ok === 1'b1) begin
                if (iq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL inst_data_ok_spurious cyc=%0d act=1 exp=0", cyc);
                end else begin
                    e = iq.pop_front();
                    check("inst_resp_cycle", cyc, e.due);
                    check("inst_rdata", bus.inst_rdata, e.data);
                end
            end else if (iq.size() > 0 && iq[0].due <= cyc) begin
                void'(iq.pop_front());
                checks++; errors++;
                $display("FAIL inst_data_ok_missing cyc=%0d act=%b exp=1", cyc, bus.inst_data_ok);
            end
            if (bus.data_data_ok === 1'b1) begin
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL data_data_ok_spurious cyc=%0d act=1 exp=0", cyc);
                end else begin
                    e = dq.pop_front();
                    check("data_resp_cycle", cyc, e.due);
                    if (!e.wr) check("data_rdata", bus.data_rdata, e.data);
                end
            end else if (dq.size() > 0 && dq[0].due <= cyc) begin
                void'(dq.pop_front());
                checks++; errors++;
                $display("FAIL data_data_ok_missing cyc=%0d act=%b exp=1", cyc, bus.data_data_ok);
            end
        end
    end

    // ---------------- Stimulus ------------------------------------------------
    initial begin
`ifdef ARB_PERF_EN
        logic [31:0] s_i, s_d, s_c;
`endif
        bus.inst_req = 1'b0; bus.inst_addr = '0;
        bus.data_req = 1'b0; bus.data_addr = '0; bus.data_wen = '0; bus.data_wdata = '0;

        // Reset: everything quiet, even with a request presented
        rst_v = 1'b1;
        repeat (2) step();
        inst_pend = 1'b1; ia = 32'h40;
        step();
        rst_v = 1'b0;
        step();   // held fetch granted right after reset

        // Fetch stream 0x0, 0x4, 0x8: one grant per cycle
        for (int k = 0; k < 3; k++) begin
            inst_pend = 1'b1; ia = 32'(k * 4);
            step();
        end
        step();

        // Both requests held for 10 cycles: D,D,D,D,I,D,D,D,D,I
`ifdef ARB_PERF_EN
        s_i = p_i; s_d = p_d; s_c = p_c;
`endif
        for (int k = 0; k < 10; k++) begin
            if (!inst_pend) begin inst_pend = 1'b1; ia = rand_addr(); end
            if (!data_pend) begin data_pend = 1'b1; da = rand_addr(); dwe = 4'h0; end
            step();
            check("starve_pattern", 32'(last_gi), 32'((k % 5) == 4));
        end
        step();   // leftover data request drains; counters now cover the 10 cycles
`ifdef ARB_PERF_EN
        check("perf_conflicts_delta", p_c - s_c, 32'd10);
        check("perf_data_delta", p_d - s_d, 32'd8);
        check("perf_inst_delta", p_i - s_i, 32'd2);
`endif
        step();

        // Store then load 0x100
        data_pend = 1'b1; da = 32'h100; dwe = 4'hF; dwd = 32'hDEADBEEF;
        step();
        data_pend = 1'b1; da = 32'h100; dwe = 4'h0;
        step();
        step();

        // Cancel right after a fetch grant
        inst_pend = 1'b1; ia = 32'h20;
        step();
        can_v = 1'b1; inst_pend = 1'b1; ia = 32'h24;
        step();
        can_v = 1'b0;
        step();
        step();

        // Reset right after a data grant
        data_pend = 1'b1; da = 32'h44; dwe = 4'h0;
        step();
        rst_v = 1'b1; data_pend = 1'b1; da = 32'h48;
        step();
        rst_v = 1'b0;
        step();
        step();

        // Randomised traffic with occasional flushes and resets
        for (int k = 0; k < 800; k++) begin
            if (!inst_pend && $urandom_range(0, 99) < 60) begin
                inst_pend = 1'b1; ia = rand_addr();
            end
            if (!data_pend && $urandom_range(0, 99) < 60) begin
                data_pend = 1'b1; da = rand_addr();
                dwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                dwd = $urandom;
            end
            can_v = ($urandom_range(0, 99) < 4);
            rst_v = ($urandom_range(0, 299) == 0);
            step();
        end
        can_v = 1'b0; rst_v = 1'b0;

        // Drain, bounded
        for (int k = 0; k < 20 && (inst_pend || data_pend); k++) step();
        check("drain_done", 32'(inst_pend | data_pend), 32'h0);
        repeat (3) step();
        check("inst_queue_empty", iq.size(), 0);
        check("data_queue_empty", dq.size(), 0);
`ifdef ARB_PERF_EN
        check("perf_inst_total", p_i, 32'(n_i));
        check("perf_data_total", p_d, 32'(n_d));
        check("perf_conflicts_total", p_c, 32'(n_c));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
